// File: rtl/universal_load_register.sv
// WIDTH-bit datapath register with load, shift, rotate and count modes.
// Flags (carry, sout, zero) are registered alongside q and updated with it.
module universal_load_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SHR_ARITH   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic             r_carry;
  logic             r_zero;

  logic [WIDTH-1:0] w_q_next;
  logic             w_sout_next;
  logic             w_carry_next;
  logic             w_zero_next;
  logic             w_write;
  logic             w_shr_fill;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;

  // The extra top bit of the widened sum/difference is the wrap indicator.
  assign w_inc      = {1'b0, r_q} + {{WIDTH{1'b0}}, 1'b1};
  assign w_dec      = {1'b0, r_q} - {{WIDTH{1'b0}}, 1'b1};
  assign w_shr_fill = SHR_ARITH ? r_q[WIDTH-1] : sin;

  always_comb begin
    w_q_next     = r_q;
    w_sout_next  = r_sout;
    w_carry_next = r_carry;
    w_write      = 1'b0;
    if (clr) begin
      w_q_next     = '0;
      w_sout_next  = 1'b0;
      w_carry_next = 1'b0;
      w_write      = 1'b1;
    end else if (en) begin
      case (mode_e'(mode))
        MODE_HOLD: begin
          w_write = 1'b0;
        end
        MODE_LOAD: begin
          w_q_next     = d;
          w_carry_next = 1'b0;
          w_write      = 1'b1;
        end
        MODE_SHL: begin
          w_q_next     = {r_q[WIDTH-2:0], sin};
          w_carry_next = r_q[WIDTH-1];
          w_sout_next  = r_q[WIDTH-1];
          w_write      = 1'b1;
        end
        MODE_SHR: begin
          w_q_next     = {w_shr_fill, r_q[WIDTH-1:1]};
          w_carry_next = r_q[0];
          w_sout_next  = r_q[0];
          w_write      = 1'b1;
        end
        MODE_ROL: begin
          w_q_next     = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_carry_next = r_q[WIDTH-1];
          w_sout_next  = r_q[WIDTH-1];
          w_write      = 1'b1;
        end
        MODE_ROR: begin
          w_q_next     = {r_q[0], r_q[WIDTH-1:1]};
          w_carry_next = r_q[0];
          w_sout_next  = r_q[0];
          w_write      = 1'b1;
        end
        MODE_INC: begin
          w_q_next     = w_inc[WIDTH-1:0];
          w_carry_next = w_inc[WIDTH];
          w_write      = 1'b1;
        end
        MODE_DEC: begin
          w_q_next     = w_dec[WIDTH-1:0];
          w_carry_next = w_dec[WIDTH];
          w_write      = 1'b1;
        end
        default: begin
          w_write = 1'b0;
        end
      endcase
    end
    // zero tracks the value being written, so hold cycles leave it alone
    w_zero_next = w_write ? (w_q_next == '0) : r_zero;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= RESET_VALUE;
      r_sout  <= 1'b0;
      r_carry <= 1'b0;
      r_zero  <= (RESET_VALUE == '0);
    end else begin
      r_q     <= w_q_next;
      r_sout  <= w_sout_next;
      r_carry <= w_carry_next;
      r_zero  <= w_zero_next;
    end
  end

  assign q     = r_q;
  assign sout  = r_sout;
  assign carry = r_carry;
  assign zero  = r_zero;

endmodule

// File: tb/tb_universal_load_register.sv
// Drives three register variants (default, arithmetic right shift, reset value 0F)
// with shared stimulus and compares them against an integer reference model.
module tb_universal_load_register;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin;

  logic [7:0] q0, q1, q2;
  logic       s0, s1, s2, c0, c1, c2, z0, z1, z2;

  logic [7:0] dq [3];
  logic       ds [3];
  logic       dc [3];
  logic       dz [3];

  int mq [3];
  int ms [3];
  int mc [3];
  int mz [3];
  int rv [3];
  int arith [3];

  int nvec;
  int nerr;

  universal_load_register #(.WIDTH(8), .RESET_VALUE(8'h00), .SHR_ARITH(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .d(d), .sin(sin),
    .q(q0), .sout(s0), .carry(c0), .zero(z0));
  universal_load_register #(.WIDTH(8), .RESET_VALUE(8'h00), .SHR_ARITH(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .d(d), .sin(sin),
    .q(q1), .sout(s1), .carry(c1), .zero(z1));
  universal_load_register #(.WIDTH(8), .RESET_VALUE(8'h0F), .SHR_ARITH(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .d(d), .sin(sin),
    .q(q2), .sout(s2), .carry(c2), .zero(z2));

  assign dq[0] = q0;
  assign dq[1] = q1;
  assign dq[2] = q2;
  assign ds[0] = s0;
  assign ds[1] = s1;
  assign ds[2] = s2;
  assign dc[0] = c0;
  assign dc[1] = c1;
  assign dc[2] = c2;
  assign dz[0] = z0;
  assign dz[1] = z1;
  assign dz[2] = z2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k] = rv[k];
      ms[k] = 0;
      mc[k] = 0;
      mz[k] = (rv[k] == 0) ? 1 : 0;
    end
  endtask

  // Register behaviour expressed as unsigned integer arithmetic on 0..255
  task automatic model_step(int k);
    int v;
    int b;
    v = mq[k];
    if (clr) begin
      mq[k] = 0; mc[k] = 0; ms[k] = 0; mz[k] = 1;
    end else if (en && mode != 3'd0) begin
      case (mode)
        3'd1: begin mq[k] = int'(d); mc[k] = 0; end
        3'd2: begin b = v / 128; mq[k] = (v * 2 + int'(sin)) % 256; mc[k] = b; ms[k] = b; end
        3'd3: begin
          b = v % 2;
          mq[k] = v / 2 + 128 * ((arith[k] != 0) ? (v / 128) : int'(sin));
          mc[k] = b; ms[k] = b;
        end
        3'd4: begin b = v / 128; mq[k] = (v * 2) % 256 + b; mc[k] = b; ms[k] = b; end
        3'd5: begin b = v % 2; mq[k] = v / 2 + 128 * b; mc[k] = b; ms[k] = b; end
        3'd6: begin mq[k] = (v + 1) % 256; mc[k] = (v == 255) ? 1 : 0; end
        default: begin mq[k] = (v + 255) % 256; mc[k] = (v == 0) ? 1 : 0; end
      endcase
      mz[k] = (mq[k] == 0) ? 1 : 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input logic [2:0] m,
                       input logic [7:0] dv, input logic s);
    en = e; clr = c; mode = m; d = dv; sin = s;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 3'd1, 8'h5A, 1'b0);
    tick();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if ({dq[k], dc[k], ds[k], dz[k]} !== {8'(mq[k]), 1'(mc[k]), 1'(ms[k]), 1'(mz[k])}) begin
        nerr++;
        $display("FAIL reset inst%0d got q=%h c=%b s=%b z=%b want q=%h c=%0d s=%0d z=%0d",
                 k, dq[k], dc[k], ds[k], dz[k], mq[k], mc[k], ms[k], mz[k]);
      end
    end
    #2;
    rst = 1'b0;
  endtask

  task automatic test_load_hold();
    drive(1'b1, 1'b0, 3'd1, 8'hA5, 1'b0);
    tick();
    nvec++;
    if ({q0, c0, z0} !== {8'hA5, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL load got q=%h c=%b z=%b want q=a5 c=0 z=0", q0, c0, z0);
    end
    drive(1'b0, 1'b0, 3'd1, 8'h3C, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if ({dq[k], dc[k], ds[k], dz[k]} !== {8'(mq[k]), 1'(mc[k]), 1'(ms[k]), 1'(mz[k])}) begin
        nerr++;
        $display("FAIL hold_en0 inst%0d got q=%h c=%b s=%b z=%b want q=%h c=%0d s=%0d z=%0d",
                 k, dq[k], dc[k], ds[k], dz[k], mq[k], mc[k], ms[k], mz[k]);
      end
    end
  endtask

  task automatic test_shifts();
    drive(1'b1, 1'b0, 3'd1, 8'hA5, 1'b0);
    tick();
    drive(1'b1, 1'b0, 3'd2, 8'h00, 1'b1);
    tick();
    nvec++;
    if ({q0, c0, s0} !== {8'h4B, 1'b1, 1'b1}) begin
      nerr++;
      $display("FAIL shl got q=%h c=%b s=%b want q=4b c=1 s=1", q0, c0, s0);
    end
    drive(1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
    tick();
    nvec++;
    if ({q0, c0, s0} !== {8'h25, 1'b1, 1'b1}) begin
      nerr++;
      $display("FAIL shr got q=%h c=%b s=%b want q=25 c=1 s=1", q0, c0, s0);
    end
    drive(1'b1, 1'b0, 3'd1, 8'h80, 1'b0);
    tick();
    drive(1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
    tick();
    nvec++;
    if ({q1, c1} !== {8'hC0, 1'b0}) begin
      nerr++;
      $display("FAIL shr_arith got q=%h c=%b want q=c0 c=0", q1, c1);
    end
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if ({dq[k], dc[k], ds[k], dz[k]} !== {8'(mq[k]), 1'(mc[k]), 1'(ms[k]), 1'(mz[k])}) begin
        nerr++;
        $display("FAIL shifts inst%0d got q=%h c=%b s=%b z=%b want q=%h c=%0d s=%0d z=%0d",
                 k, dq[k], dc[k], ds[k], dz[k], mq[k], mc[k], ms[k], mz[k]);
      end
    end
  endtask

  task automatic test_rotates();
    drive(1'b1, 1'b0, 3'd1, 8'h81, 1'b0);
    tick();
    drive(1'b1, 1'b0, 3'd4, 8'h00, 1'b0);
    tick();
    nvec++;
    if ({q0, c0} !== {8'h03, 1'b1}) begin
      nerr++;
      $display("FAIL rol got q=%h c=%b want q=03 c=1", q0, c0);
    end
    drive(1'b1, 1'b0, 3'd1, 8'h81, 1'b0);
    tick();
    drive(1'b1, 1'b0, 3'd5, 8'h00, 1'b1);
    tick();
    nvec++;
    if ({q0, c0} !== {8'hC0, 1'b1}) begin
      nerr++;
      $display("FAIL ror1 got q=%h c=%b want q=c0 c=1", q0, c0);
    end
    tick();
    nvec++;
    if ({q0, c0, s0} !== {8'h60, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL ror2 got q=%h c=%b s=%b want q=60 c=0 s=0", q0, c0, s0);
    end
  endtask

  task automatic test_counter();
    logic [7:0] exp_q [5];
    logic       exp_c [5];
    logic       exp_z [5];
    logic [2:0] op    [5];
    exp_q = '{8'hFE, 8'hFF, 8'h00, 8'hFF, 8'hFE};
    exp_c = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_z = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    op    = '{3'd1, 3'd6, 3'd6, 3'd7, 3'd7};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, op[i], 8'hFE, 1'b0);
      tick();
      nvec++;
      if ({q0, c0, z0} !== {exp_q[i], exp_c[i], exp_z[i]}) begin
        nerr++;
        $display("FAIL counter step%0d got q=%h c=%b z=%b want q=%h c=%b z=%b",
                 i, q0, c0, z0, exp_q[i], exp_c[i], exp_z[i]);
      end
    end
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b0, 3'd1, 8'h5A, 1'b0);
    tick();
    drive(1'b1, 1'b1, 3'd1, 8'h77, 1'b0);
    tick();
    nvec++;
    if ({q0, z0, c0} !== {8'h00, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL clr_over_load got q=%h z=%b c=%b want q=00 z=1 c=0", q0, z0, c0);
    end
    drive(1'b1, 1'b0, 3'd1, 8'h5A, 1'b0);
    tick();
    drive(1'b0, 1'b1, 3'd1, 8'h77, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if ({dq[k], dc[k], ds[k], dz[k]} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
        nerr++;
        $display("FAIL clr_en0 inst%0d got q=%h c=%b s=%b z=%b want q=00 c=0 s=0 z=1",
                 k, dq[k], dc[k], ds[k], dz[k]);
      end
    end
  endtask

  task automatic test_reset_midshift();
    drive(1'b1, 1'b0, 3'd1, 8'h3C, 1'b0);
    tick();
    drive(1'b1, 1'b0, 3'd2, 8'h00, 1'b0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    nvec++;
    if (q2 !== 8'h0F) begin
      nerr++;
      $display("FAIL rst_midshift_async got q=%h want q=0f", q2);
    end
    #3;
    rst = 1'b0;
    tick();
    nvec++;
    if (q2 !== 8'h1E) begin
      nerr++;
      $display("FAIL rst_midshift_next got q=%h want q=1e", q2);
    end
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if ({dq[k], dc[k], ds[k], dz[k]} !== {8'(mq[k]), 1'(mc[k]), 1'(ms[k]), 1'(mz[k])}) begin
        nerr++;
        $display("FAIL rst_midshift inst%0d got q=%h c=%b s=%b z=%b want q=%h c=%0d s=%0d z=%0d",
                 k, dq[k], dc[k], ds[k], dz[k], mq[k], mc[k], ms[k], mz[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
            3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));
      tick();
      for (int k = 0; k < 3; k++) begin
        nvec++;
        if ({dq[k], dc[k], ds[k], dz[k]} !== {8'(mq[k]), 1'(mc[k]), 1'(ms[k]), 1'(mz[k])}) begin
          nerr++;
          $display("FAIL random cyc%0d inst%0d got q=%h c=%b s=%b z=%b want q=%h c=%0d s=%0d z=%0d",
                   i, k, dq[k], dc[k], ds[k], dz[k], mq[k], mc[k], ms[k], mz[k]);
        end
      end
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rv    = '{0, 0, 15};
    arith = '{0, 1, 0};
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_load_hold();
    test_shifts();
    test_rotates();
    test_counter();
    test_priority();
    test_reset_midshift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
